// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue/capture stage wrapped around the combinational ALU (including its
// logical left-shift unit). One operation is accepted from the decode /
// register-read stage and its operands are held stable on the ALU inputs for
// SETTLE cycles. The result and flags are then captured into an output
// register and offered to the writeback stage.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   upstream handshake; in_ready is high only in IDLE
//   in_a, in_b, in_sel    operands and function select (sampled in IDLE only)
//   alu_a, alu_b, alu_sel registered operands/select driven into the ALU
//   alu_res, alu_carry    combinational ALU result and carry/borrow
//   out_valid / out_ready downstream handshake for the captured result
//   out_res, out_zero,    captured result, zero flag, captured carry
//   out_carry
//   busy                  high while an operation is in EXEC or HOLD
//   ops_done              saturating count of delivered results
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
   parameter int WIDTH  = 6,
   parameter int SEL_W  = 4,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [SEL_W-1:0] in_sel,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [SEL_W-1:0] alu_sel,
   input  logic [WIDTH-1:0] alu_res,
   input  logic             alu_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic             out_zero,
   output logic             out_carry,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done
);

   // A zero settle time would capture before the ALU has seen the operands.
   generate
      if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
         $error("alu_issue_ctrl: SETTLE must be in 1..15");
      end
   endgenerate

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   // Counter is loaded with SETTLE-1 so EXEC spans exactly SETTLE cycles,
   // the last of which (count==0) is the capture edge.
   localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

   logic [1:0] state_reg;
   logic [3:0] cnt_reg;

   // Decoded from the state register only: no combinational path from
   // in_valid or out_ready to either handshake output.
   assign in_ready = (state_reg == ST_IDLE);
   assign busy     = (state_reg != ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         out_res   <= '0;
         out_zero  <= 1'b0;
         out_carry <= 1'b0;
         out_valid <= 1'b0;
         ops_done  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               // alu_* keep their previous values while idle.
               if (in_valid) begin
                  alu_a     <= in_a;
                  alu_b     <= in_b;
                  alu_sel   <= in_sel;
                  cnt_reg   <= SETTLE_M1;
                  state_reg <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (cnt_reg != 4'd0) begin
                  cnt_reg <= cnt_reg - 4'd1;
               end else begin
                  out_res   <= alu_res;
                  out_zero  <= (alu_res == '0);
                  out_carry <= alu_carry;
                  out_valid <= 1'b1;
                  state_reg <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               // Result register stays frozen until downstream takes it.
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  if (ops_done != {CNT_W{1'b1}}) begin
                     ops_done <= ops_done + CNT_W'(1);
                  end
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential issue/capture stage wrapped around the combinational 6-bit ALU, which includes the logical left-shift unit.
- Accepts one operation (operands + function select) over a valid/ready handshake and holds the operands stable on the ALU inputs for a programmable settle time.
- Captures result and flags into an output register, then presents them downstream over a second valid/ready handshake.
- Sits between the decode/register-read stage (upstream) and the writeback stage (downstream).

Parameters:
- WIDTH, 6, datapath width of operands and result.
- SEL_W, 4, width of ALU function select.
- SETTLE, 2, number of EXEC cycles operands are held before capture; legal range 1..15; 0 is illegal (generate-time error).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream offers an operation.
- in_ready  output  1  block can accept an operation.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B (shift amount for shift ops).
- in_sel  input  SEL_W  ALU function select.
- alu_a  output  WIDTH  registered operand A to ALU.
- alu_b  output  WIDTH  registered operand B to ALU.
- alu_sel  output  SEL_W  registered select to ALU.
- alu_res  input  WIDTH  ALU combinational result.
- alu_carry  input  1  ALU carry/borrow out.
- out_valid  output  1  result register holds an undelivered result.
- out_ready  input  1  downstream accepts result.
- out_res  output  WIDTH  captured result.
- out_zero  output  1  captured result equals 0.
- out_carry  output  1  captured alu_carry.
- busy  output  1  high in EXEC or HOLD.
- ops_done  output  CNT_W  completed-operation count, saturating.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE; alu_a, alu_b, alu_sel, out_res, out_zero, out_carry, ops_done all 0; out_valid=0; settle counter=0; any in-flight op discarded.
- States: IDLE, EXEC, HOLD.
- in_ready = (state==IDLE); purely state-decoded, no combinational path from out_ready or in_valid.
- busy = (state!=IDLE).
- IDLE: on in_valid&&in_ready at edge k:
  - register in_a/in_b/in_sel into alu_a/alu_b/alu_sel;
  - load counter=SETTLE-1; go EXEC.
  - Without in_valid, stay IDLE; alu_* keep their last values.
- EXEC:
  - alu_* held constant throughout.
  - If counter!=0: decrement, stay EXEC.
  - If counter==0: capture out_res=alu_res, out_zero=(alu_res==0), out_carry=alu_carry; set out_valid=1; go HOLD.
  - EXEC therefore lasts exactly SETTLE cycles; out_valid first seen high after edge k+SETTLE.
- HOLD:
  - out_res/out_zero/out_carry/out_valid stable until handshake.
  - On out_valid&&out_ready: clear out_valid next edge; ops_done += 1 unless already all-ones (saturate at 2^CNT_W-1); go IDLE.
  - Otherwise stay HOLD indefinitely (backpressure).
- Throughput: one op per SETTLE+2 cycles at best (accept, SETTLE exec, handshake; IDLE cycle before next accept).
- in_valid while not in_ready is ignored; upstream must hold the op. The block never samples in_* outside IDLE.
- out_ready while out_valid=0 has no effect.
- Result values are pass-through: no interpretation of in_sel. Shift-range handling (B≥6 → 0) belongs to the ALU.
- All outputs registered except in_ready and busy, which decode the state register only.

Test Plan:
- Reset mid-EXEC: accept a=6'h03, b=6'd2; assert rst one cycle later → immediately state IDLE, in_ready=1, out_valid=0, alu_a=0, ops_done=0; no result ever appears.
- Basic shift, SETTLE=2, ALU model = left shift: a=6'b000011, b=6'd2, out_ready=1 → out_valid high exactly 2 cycles after the accept edge, out_res=6'b001100, out_zero=0; ops_done=1 after handshake.
- Shift out of range: a=6'h3F, b=6'd8 (model returns 0) → out_res=0, out_zero=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_res/flags stable; in_ready=0 throughout; in_valid pulses ignored; out_ready=1 → out_valid drops next edge, in_ready rises.
- Back-to-back: three ops with in_valid held and out_ready=1, SETTLE=1 → accepts spaced exactly 3 cycles apart, results in order, ops_done=3.
- Saturation with CNT_W=2: complete 5 ops → ops_done reads 1,2,3,3,3.
